// File: rtl/md_ring_pkg.sv
// Shared types and helpers for the force-writeback ring.
// Default widths describe the production 64-stop ring.
package md_ring_pkg;

    localparam int DEF_NUM_CELLS  = 64;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_PID_WIDTH  = 7;
    localparam int DEF_INJ_DEPTH  = 4;

    function automatic int node_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PACKET_WIDTH =
        3 * DEF_DATA_WIDTH + DEF_PID_WIDTH + node_w(DEF_NUM_CELLS);

    typedef struct packed {
        logic [node_w(DEF_NUM_CELLS)-1:0] dst;
        logic [DEF_PID_WIDTH-1:0]         pid;
        logic [DEF_DATA_WIDTH-1:0]        fz;
        logic [DEF_DATA_WIDTH-1:0]        fy;
        logic [DEF_DATA_WIDTH-1:0]        fx;
    } force_pkt_t;

endpackage

// File: rtl/ring_inj_fifo.sv
// Local injection FIFO for one ring stop.
// Count-based full/empty; ready is registered from the next count.
module ring_inj_fifo #(
    parameter int WIDTH = 105,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_count;
    logic             r_ready;
    logic [AW:0]      w_cnt_nxt;

    assign w_cnt_nxt = r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop)  r_rd <= r_rd + AW'(1);
            r_count <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt < FULL);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end

    assign o_data  = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_ready = r_ready;

endmodule

// File: rtl/force_ring_stop.sv
// One stop of the bufferless force-writeback ring: forwards through-traffic,
// ejects packets for this node and injects local packets into free slots.
module force_ring_stop #(
    parameter int NUM_CELLS         = md_ring_pkg::DEF_NUM_CELLS,
    parameter int NODE_ID           = 0,
    parameter int DATA_WIDTH        = md_ring_pkg::DEF_DATA_WIDTH,
    parameter int PARTICLE_ID_WIDTH = md_ring_pkg::DEF_PID_WIDTH,
    parameter int NODE_ID_WIDTH     = md_ring_pkg::node_w(NUM_CELLS),
    parameter int FORCE_DATA_WIDTH  = 3*DATA_WIDTH + PARTICLE_ID_WIDTH,
    parameter int PACKET_WIDTH      = FORCE_DATA_WIDTH + NODE_ID_WIDTH,
    parameter int INJ_DEPTH         = md_ring_pkg::DEF_INJ_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PACKET_WIDTH-1:0]     packet_in,
    input  logic                        packet_valid,
    output logic                        ready,
    input  logic [PACKET_WIDTH-1:0]     ring_in_pkt,
    input  logic                        ring_in_valid,
    output logic [PACKET_WIDTH-1:0]     ring_out_pkt,
    output logic                        ring_out_valid,
    output logic [FORCE_DATA_WIDTH-1:0] data_out,
    output logic                        data_valid,
    output logic                        idle,
    output logic                        bad_dst
);

    import md_ring_pkg::*;

    localparam logic [NODE_ID_WIDTH-1:0] SELF = NODE_ID[NODE_ID_WIDTH-1:0];

    logic [PACKET_WIDTH-1:0]     w_head;
    logic                        w_empty;
    logic                        w_fifo_rdy;
    logic                        w_push;
    logic                        w_pop;
    logic [NODE_ID_WIDTH-1:0]    w_rin_dst;
    logic [NODE_ID_WIDTH-1:0]    w_head_dst;
    logic                        w_rin_bad;
    logic                        w_head_bad;
    logic                        w_rin_drop;
    logic                        w_head_drop;
    logic                        w_eject_ring;
    logic                        w_fwd;
    logic                        w_eject_head;
    logic                        w_inj_head;

    logic [PACKET_WIDTH-1:0]     r_ring_pkt;
    logic                        r_ring_v;
    logic [FORCE_DATA_WIDTH-1:0] r_data;
    logic                        r_data_v;
    logic                        r_bad;

    assign w_push = packet_valid & w_fifo_rdy;

    ring_inj_fifo #(
        .WIDTH (PACKET_WIDTH),
        .DEPTH (INJ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  (packet_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_ready (w_fifo_rdy)
    );

    assign w_rin_dst  = ring_in_pkt[PACKET_WIDTH-1 -: NODE_ID_WIDTH];
    assign w_head_dst = w_head[PACKET_WIDTH-1 -: NODE_ID_WIDTH];

    // Out-of-range destinations only exist when NUM_CELLS is not a power of 2.
    if ((1 << NODE_ID_WIDTH) > NUM_CELLS) begin : g_dst_chk
        localparam logic [NODE_ID_WIDTH-1:0] LIM =
            NUM_CELLS[NODE_ID_WIDTH-1:0];
        assign w_rin_bad  = (w_rin_dst >= LIM);
        assign w_head_bad = (w_head_dst >= LIM);
    end else begin : g_no_chk
        assign w_rin_bad  = 1'b0;
        assign w_head_bad = 1'b0;
    end

    assign w_rin_drop   = ring_in_valid & w_rin_bad;
    assign w_eject_ring = ring_in_valid & ~w_rin_bad & (w_rin_dst == SELF);
    assign w_fwd        = ring_in_valid & ~w_rin_bad & (w_rin_dst != SELF);

    // Through-traffic owns both paths; the FIFO head takes what is left.
    assign w_head_drop  = ~w_empty & w_head_bad;
    assign w_eject_head = ~w_empty & ~w_head_bad & (w_head_dst == SELF)
                        & ~w_eject_ring;
    assign w_inj_head   = ~w_empty & ~w_head_bad & (w_head_dst != SELF)
                        & ~w_fwd;
    assign w_pop        = w_head_drop | w_eject_head | w_inj_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ring_pkt <= '0;
            r_ring_v   <= 1'b0;
            r_data     <= '0;
            r_data_v   <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            r_ring_v <= w_fwd | w_inj_head;
            if (w_fwd)
                r_ring_pkt <= ring_in_pkt;
            else if (w_inj_head)
                r_ring_pkt <= w_head;
            r_data_v <= w_eject_ring | w_eject_head;
            if (w_eject_ring)
                r_data <= ring_in_pkt[FORCE_DATA_WIDTH-1:0];
            else if (w_eject_head)
                r_data <= w_head[FORCE_DATA_WIDTH-1:0];
            if (w_rin_drop | w_head_drop)
                r_bad <= 1'b1;
        end
    end

    a_no_bad_dst: assert property (
        @(posedge clk) disable iff (!rst) !(w_rin_drop | w_head_drop)
    );

    assign ready          = w_fifo_rdy;
    assign ring_out_pkt   = r_ring_pkt;
    assign ring_out_valid = r_ring_v;
    assign data_out       = r_data;
    assign data_valid     = r_data_v;
    assign bad_dst        = r_bad;
    assign idle           = w_empty & ~r_ring_v & ~r_data_v;

endmodule

// File: tb/tb_force_ring_stop.sv
// Directed and random checks of one ring stop against a queue-based model.
// Configuration: 4 stops, this stop is node 2, injection depth 4.
module tb_force_ring_stop;

    localparam int NC  = 4;
    localparam int NID = 2;
    localparam int DW  = 32;
    localparam int PW  = 7;
    localparam int FDW = 3*DW + PW;
    localparam int PKW = FDW + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [PKW-1:0] packet_in = '0;
    logic           packet_valid = 1'b0;
    logic           ready;
    logic [PKW-1:0] ring_in_pkt = '0;
    logic           ring_in_valid = 1'b0;
    logic [PKW-1:0] ring_out_pkt;
    logic           ring_out_valid;
    logic [FDW-1:0] data_out;
    logic           data_valid;
    logic           idle;
    logic           bad_dst;

    force_ring_stop #(
        .NUM_CELLS         (NC),
        .NODE_ID           (NID),
        .DATA_WIDTH        (DW),
        .PARTICLE_ID_WIDTH (PW),
        .INJ_DEPTH         (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .packet_in      (packet_in),
        .packet_valid   (packet_valid),
        .ready          (ready),
        .ring_in_pkt    (ring_in_pkt),
        .ring_in_valid  (ring_in_valid),
        .ring_out_pkt   (ring_out_pkt),
        .ring_out_valid (ring_out_valid),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .idle           (idle),
        .bad_dst        (bad_dst)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [PKW-1:0] m_q[$];
    logic           m_ready = 1'b0;
    logic           m_rv = 1'b0;
    logic [PKW-1:0] m_rpkt = '0;
    logic           m_dv = 1'b0;
    logic [FDW-1:0] m_data = '0;

    function automatic logic [PKW-1:0] mk(input int dst, input int pid,
                                          input logic [31:0] fx);
        logic [1:0] d;
        logic [6:0] p;
        d = dst[1:0];
        p = pid[6:0];
        return {d, p, $urandom(), $urandom(), fx};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ready = 1'b0;
        m_rv    = 1'b0;
        m_dv    = 1'b0;
    endtask

    task automatic model_tick(input logic rv, input logic [PKW-1:0] rp,
                              input logic pv, input logic [PKW-1:0] pp);
        logic push, slot_busy, ej_used;
        logic [PKW-1:0] h;
        push = pv && m_ready;
        m_rv = 1'b0;
        m_dv = 1'b0;
        slot_busy = 1'b0;
        ej_used = 1'b0;
        if (rv) begin
            if (int'(rp[PKW-1 -: 2]) == NID) begin
                m_dv = 1'b1; m_data = rp[FDW-1:0]; ej_used = 1'b1;
            end else begin
                m_rv = 1'b1; m_rpkt = rp; slot_busy = 1'b1;
            end
        end
        if (m_q.size() > 0) begin
            h = m_q[0];
            if (int'(h[PKW-1 -: 2]) == NID) begin
                if (!ej_used) begin
                    m_dv = 1'b1; m_data = h[FDW-1:0];
                    void'(m_q.pop_front());
                end
            end else if (!slot_busy) begin
                m_rv = 1'b1; m_rpkt = h;
                void'(m_q.pop_front());
            end
        end
        if (push) m_q.push_back(pp);
        m_ready = (m_q.size() < 4);
    endtask

    task automatic check_all();
        chk("ring_out_valid", 128'(ring_out_valid), 128'(m_rv));
        if (m_rv) chk("ring_out_pkt", 128'(ring_out_pkt), 128'(m_rpkt));
        chk("data_valid", 128'(data_valid), 128'(m_dv));
        if (m_dv) chk("data_out", 128'(data_out), 128'(m_data));
        chk("ready", 128'(ready), 128'(m_ready));
        chk("idle", 128'(idle),
            128'((m_q.size() == 0) && !m_rv && !m_dv));
        chk("bad_dst", 128'(bad_dst), 128'(0));
    endtask

    task automatic step(input logic rv, input logic [PKW-1:0] rp,
                        input logic pv, input logic [PKW-1:0] pp);
        ring_in_valid = rv;
        ring_in_pkt   = rp;
        packet_valid  = pv;
        packet_in     = pp;
        @(posedge clk);
        model_tick(rv, rp, pv, pp);
        #1;
        check_all();
    endtask

    logic [PKW-1:0] pa, pb, pc;
    logic [PKW-1:0] zero_pkt;

    initial begin
        zero_pkt = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 128'(ready), 128'(0));
        chk("rst_ring_v", 128'(ring_out_valid), 128'(0));
        chk("rst_data_v", 128'(data_valid), 128'(0));
        chk("rst_idle", 128'(idle), 128'(1));
        chk("rst_bad", 128'(bad_dst), 128'(0));
        chk("rst_ring_pkt", 128'(ring_out_pkt), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, zero_pkt, 1'b0, zero_pkt);
        chk("ready_rise", 128'(ready), 128'(1));

        // Pass-through
        pa = mk(3, 5, 32'h11);
        step(1'b1, pa, 1'b0, zero_pkt);
        chk("pt_v", 128'(ring_out_valid), 128'(1));
        chk("pt_pkt", 128'(ring_out_pkt), 128'(pa));
        chk("pt_dv", 128'(data_valid), 128'(0));
        step(1'b0, zero_pkt, 1'b0, zero_pkt);

        // Eject
        pa = mk(2, 9, 32'h1);
        step(1'b1, pa, 1'b0, zero_pkt);
        chk("ej_dv", 128'(data_valid), 128'(1));
        chk("ej_data", 128'(data_out), 128'(pa[FDW-1:0]));
        chk("ej_pid", 128'(data_out[FDW-1 -: 7]), 128'(9));
        chk("ej_rv", 128'(ring_out_valid), 128'(0));
        step(1'b0, zero_pkt, 1'b0, zero_pkt);

        // Local inject on an idle ring
        pa = mk(0, 3, 32'h22);
        step(1'b0, zero_pkt, 1'b1, pa);
        chk("inj_e_rv", 128'(ring_out_valid), 128'(0));
        chk("inj_e_idle", 128'(idle), 128'(0));
        step(1'b0, zero_pkt, 1'b0, zero_pkt);
        chk("inj_e1_rv", 128'(ring_out_valid), 128'(1));
        chk("inj_e1_pkt", 128'(ring_out_pkt), 128'(pa));
        step(1'b0, zero_pkt, 1'b0, zero_pkt);
        chk("inj_idle", 128'(idle), 128'(1));

        // Contention: saturated ring holds the head; FIFO fills
        pc = mk(1, 40, 32'h100);
        for (int i = 0; i < 5; i++) begin
            pb = mk(1, 40 + i, 32'h100 + i);
            if (i == 0) pb = pc;
            step(1'b1, mk(3, 60 + i, 32'h200 + i), 1'b1, pb);
            if (i == 3) chk("cont_full", 128'(ready), 128'(0));
        end
        step(1'b0, zero_pkt, 1'b0, zero_pkt);
        chk("cont_inj_v", 128'(ring_out_valid), 128'(1));
        chk("cont_inj_pkt", 128'(ring_out_pkt), 128'(pc));
        repeat (5) step(1'b0, zero_pkt, 1'b0, zero_pkt);

        // Self-traffic vs eject
        pa = mk(2, 20, 32'haa);
        pb = mk(2, 21, 32'hbb);
        step(1'b0, zero_pkt, 1'b1, pa);
        step(1'b1, pb, 1'b0, zero_pkt);
        chk("self_first", 128'(data_out), 128'(pb[FDW-1:0]));
        step(1'b0, zero_pkt, 1'b0, zero_pkt);
        chk("self_second_v", 128'(data_valid), 128'(1));
        chk("self_second", 128'(data_out), 128'(pa[FDW-1:0]));
        chk("self_no_ring", 128'(ring_out_valid), 128'(0));
        step(1'b0, zero_pkt, 1'b0, zero_pkt);

        // Reset mid-burst
        for (int i = 0; i < 3; i++)
            step(1'b1, mk(0, 70 + i, 32'h300), 1'b1, mk(3, 80 + i, 32'h400));
        rst = 1'b0;
        #1;
        chk("mrst_ready", 128'(ready), 128'(0));
        chk("mrst_rv", 128'(ring_out_valid), 128'(0));
        chk("mrst_dv", 128'(data_valid), 128'(0));
        chk("mrst_idle", 128'(idle), 128'(1));
        ring_in_valid = 1'b0;
        packet_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, zero_pkt, 1'b0, zero_pkt);
            chk("mrst_quiet", 128'(ring_out_valid | data_valid), 128'(0));
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55),
                 mk($urandom_range(0, 3), $urandom_range(0, 127), $urandom()),
                 ($urandom_range(0, 99) < 45),
                 mk($urandom_range(0, 3), $urandom_range(0, 127), $urandom()));
        end
        for (int i = 0; i < 8; i++) step(1'b0, zero_pkt, 1'b0, zero_pkt);
        chk("final_idle", 128'(idle), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
